max_scan_ctrl: RTL and testbench

Sequential controller that streams a frame of 8-bit unsigned samples through a single shared compare-and-select unit and reports the frame maximum and its position. It owns the accept handshake toward the sample source, the running-maximum register, the sample counter, and the completion pulse toward the consumer. It is the sequencing layer for the team's 8-bit maximum datapath in the lab designs.

---
 rtl/max_scan_ctrl.sv | 75 +++++++
 tb/tb_max_scan_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/max_scan_ctrl.sv
// max_scan_ctrl: streams a frame of samples through one compare-select unit, reporting max and its first index
module max_scan_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [7:0]    len_i,
  input  logic          abort_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] data_i,
  output logic          in_ready_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] max_o,
  output logic [7:0]    max_idx_o,
  output logic [8:0]    count_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [8:0]    target_q, target_d;
  logic [8:0]    count_q, count_d;
  logic [DW-1:0] max_q, max_d;
  logic [7:0]    idx_q, idx_d;
  logic          accept, take;
  logic [8:0]    count_inc;
  assign in_ready_o = (state_q == RUN) && !abort_i;
  assign accept     = in_ready_o && in_valid_i;
  assign count_inc  = count_q + 9'd1;
  assign take       = accept && ((count_q == 9'd0) || (data_i > max_q));
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign max_o      = max_q;
  assign max_idx_o  = idx_q;
  assign count_o    = count_q;
  // Next state plus target/counter/running-max updates; len of 0 maps to a 256 target.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    max_d    = take ? data_i : max_q;
    idx_d    = take ? count_q[7:0] : idx_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d  = RUN;
        target_d = {len_i == 8'd0, len_i};
        count_d  = 9'd0;
      end
      RUN: begin
        if (abort_i) state_d = IDLE;
        else if (accept) begin
          count_d = count_inc;
          state_d = (count_inc == target_q) ? DONE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 9'd0;
      count_q  <= 9'd0;
      max_q    <= '0;
      idx_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
    end
  end
endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb_max_scan_ctrl: directed frames with a done-triggered scoreboard for max_scan_ctrl
module tb_max_scan_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start_i = 1'b0, abort_i = 1'b0, in_valid_i = 1'b0;
  logic [7:0] len_i = 8'd0, data_i = 8'd0;
  logic       in_ready_o, busy_o, done_o;
  logic [7:0] max_o, max_idx_o;
  logic [8:0] count_o;
  logic [24:0] exp_q[$];
  logic [7:0] smp[256];
  int tests = 0, fails = 0;

  max_scan_ctrl #(.DW(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .data_i(data_i), .in_ready_o(in_ready_o), .busy_o(busy_o),
    .done_o(done_o), .max_o(max_o), .max_idx_o(max_idx_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected {max, idx, count} result.
  always @(negedge clk) begin
    if (!rst && done_o === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done with max=%0d idx=%0d count=%0d, expected none", max_o, max_idx_o, count_o);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if ({max_o, max_idx_o, count_o} !== e) begin
          fails++;
          $display("FAIL result: got max=%0d idx=%0d count=%0d expected max=%0d idx=%0d count=%0d",
                   max_o, max_idx_o, count_o, e[24:17], e[16:9], e[8:0]);
        end
      end
    end
  end

  task automatic frame(input logic [7:0] l, input int n, input logic [7:0] em, input logic [7:0] ei,
                       input logic [8:0] ec);
    exp_q.push_back({em, ei, ec});
    start_i = 1'b1; len_i = l;
    tick();
    start_i = 1'b0;
    chk("count_cleared", count_o, 0);
    chk("ready_in_run", in_ready_o, 1);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk("no_early_done", done_o, 0);
      in_valid_i = 1'b1; data_i = smp[i];
      tick();
    end
    in_valid_i = 1'b0;
    chk("done_pulse", done_o, 1);
    chk("done_not_ready", in_ready_o, 0);
    tick();
    chk("done_low_after", done_o, 0);
    chk("idle_after", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_max", max_o, 0);
    chk("rst_idx", max_idx_o, 0);
    chk("rst_count", count_o, 0);
    rst = 1'b0;
    smp[0] = 3; smp[1] = 9; smp[2] = 2; smp[3] = 7;
    frame(8'd4, 4, 8'd9, 8'd1, 9'd4);
    smp[0] = 0; smp[1] = 200; smp[2] = 200; smp[3] = 5; smp[4] = 200;
    frame(8'd5, 5, 8'd200, 8'd1, 9'd5);
    smp[0] = 0; smp[1] = 0; smp[2] = 0;
    frame(8'd3, 3, 8'd0, 8'd0, 9'd3);
    for (int i = 0; i < 256; i++) smp[i] = i[7:0];
    frame(8'd0, 256, 8'd255, 8'd255, 9'd256);
    // stalls with a start pulse during RUN
    exp_q.push_back({8'd8, 8'd1, 9'd3});
    start_i = 1'b1; len_i = 8'd3;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1; data_i = 8'd4; tick();
    in_valid_i = 1'b0; data_i = 8'd255; start_i = 1'b1; len_i = 8'd7; tick();
    start_i = 1'b0; tick();
    chk("stall_count", count_o, 1);
    in_valid_i = 1'b1; data_i = 8'd8; tick();
    in_valid_i = 1'b0; data_i = 8'd255; tick();
    chk("stall_no_done", done_o, 0);
    in_valid_i = 1'b1; data_i = 8'd6; tick();
    in_valid_i = 1'b0;
    chk("stall_done", done_o, 1);
    chk("stall_count_final", count_o, 3);
    tick();
    chk("stall_idle", busy_o, 0);
    // abort on the third sample
    start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1; data_i = 8'd10; tick();
    data_i = 8'd20; tick();
    data_i = 8'd30; abort_i = 1'b1;
    #1;
    chk("abort_ready_low", in_ready_o, 0);
    tick();
    abort_i = 1'b0; in_valid_i = 1'b0;
    chk("abort_idle", busy_o, 0);
    chk("abort_count", count_o, 2);
    chk("abort_max", max_o, 20);
    chk("abort_idx", max_idx_o, 1);
    repeat (3) tick();
    smp[0] = 5; smp[1] = 1;
    frame(8'd2, 2, 8'd5, 8'd0, 9'd2);
    // async reset mid-frame
    start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1; data_i = 8'd77; tick();
    data_i = 8'd99; tick();
    in_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", in_ready_o, 0);
    chk("arst_max", max_o, 0);
    chk("arst_idx", max_idx_o, 0);
    chk("arst_count", count_o, 0);
    tick();
    rst = 1'b0;
    smp[0] = 42;
    frame(8'd1, 1, 8'd42, 8'd0, 9'd1);
    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
